// File: rtl/acx_ds_arb_pkg.sv
// rtl/acx_ds_arb_pkg.sv - shared types and round-robin pick function for the data-streaming arbiter
package acx_ds_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_PKT} t_arb_state;

    localparam int MAX_REQ   = 8;
    localparam int MAX_REQ_W = 3;

    // Callers zero-pad eligible above their own requester count, so a modulo-MAX_REQ
    // wrap gives the same winner as a modulo-NUM_REQ wrap.
    function automatic logic [MAX_REQ_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   eligible,
        input logic [MAX_REQ_W-1:0] pointer
    );
        logic [MAX_REQ_W-1:0] idx;
        logic [MAX_REQ_W-1:0] win;
        logic                 found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = pointer + MAX_REQ_W'(i);
            if (!found && eligible[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/acx_rr_pick.sv
// rtl/acx_rr_pick.sv - combinational rotate-priority encoder: first eligible index at or after pointer
module acx_rr_pick
    import acx_ds_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [REQ_W-1:0]   i_pointer,
    output logic [REQ_W-1:0]   o_winner,
    output logic               o_any
);

    logic [MAX_REQ-1:0]   elig_pad;
    logic [MAX_REQ_W-1:0] ptr_pad;
    logic [MAX_REQ_W-1:0] win;

    always_comb begin
        elig_pad = MAX_REQ'(i_eligible);
        ptr_pad  = MAX_REQ_W'(i_pointer);
        win      = rr_pick(elig_pad, ptr_pad);
        o_winner = REQ_W'(win);
        o_any    = |i_eligible;
    end

endmodule

// File: rtl/nap_ds_tx_arbiter.sv
// rtl/nap_ds_tx_arbiter.sv - packet-granular round-robin arbiter onto one NAP data-streaming tx channel
// Optional per-requester packet counters under ACX_DS_ARB_STATS_EN.
module nap_ds_tx_arbiter
    import acx_ds_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 288,
    parameter  int ADDR_WIDTH = 4,
    localparam int REQ_W      = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_sop,
    input  logic [NUM_REQ-1:0]            i_req_eop,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_tx_valid,
    output logic                          o_tx_sop,
    output logic                          o_tx_eop,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic [ADDR_WIDTH-1:0]         o_tx_addr,
    input  logic                          i_tx_ready,
`ifdef ACX_DS_ARB_STATS_EN
    input  logic                          i_stats_clear,
    output logic [NUM_REQ*32-1:0]         o_pkt_count,
`endif
    output logic [REQ_W-1:0]              o_grant,
    output logic                          o_busy,
    output logic                          o_proto_err
);

    t_arb_state       state_q, state_d;
    logic [REQ_W-1:0] grant_q, grant_d;
    logic [REQ_W-1:0] ptr_q, ptr_d;
    logic             err_q, err_d;
    logic             first_q, first_d;

    logic [REQ_W-1:0] pick;
    logic             pick_any;
    logic             tx_valid, tx_sop, tx_eop;
    logic             beat_xfer;

    acx_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .i_eligible (i_req_valid & i_req_sop),
        .i_pointer  (ptr_q),
        .o_winner   (pick),
        .o_any      (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        err_d       = err_q;
        first_d     = first_q;
        tx_valid    = 1'b0;
        tx_sop      = 1'b0;
        tx_eop      = 1'b0;
        beat_xfer   = 1'b0;
        o_req_ready = '0;

        case (state_q)
            ARB_IDLE: begin
                if (|(i_req_valid & ~i_req_sop)) begin
                    err_d = 1'b1;
                end
                if (pick_any) begin
                    state_d = ARB_PKT;
                    grant_d = pick;
                    first_d = 1'b1;
                end
            end
            ARB_PKT: begin
                tx_valid             = i_req_valid[grant_q];
                tx_sop               = i_req_sop[grant_q];
                tx_eop               = i_req_eop[grant_q];
                o_req_ready[grant_q] = i_tx_ready;
                beat_xfer            = tx_valid && i_tx_ready;
                if (beat_xfer) begin
                    first_d = 1'b0;
                    // A second sop inside a packet is flagged but the beat still goes out.
                    if (tx_sop && !first_q) begin
                        err_d = 1'b1;
                    end
                    if (tx_eop) begin
                        state_d = ARB_IDLE;
                        ptr_d   = (grant_q == REQ_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign o_tx_valid  = tx_valid;
    assign o_tx_sop    = tx_sop;
    assign o_tx_eop    = tx_eop;
    assign o_tx_data   = i_req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign o_tx_addr   = i_req_addr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    assign o_grant     = grant_q;
    assign o_busy      = (state_q == ARB_PKT);
    assign o_proto_err = err_q;

`ifdef ACX_DS_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_stats_clear) begin
            cnt_d = '0;
        end else if (beat_xfer && tx_eop) begin
            cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_nap_ds_tx_arbiter.sv
// tb/tb_nap_ds_tx_arbiter.sv - directed self-checking bench for nap_ds_tx_arbiter
module tb_nap_ds_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 288;
    localparam int AW = 4;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid, req_sop, req_eop;
    logic [NR*DW-1:0] req_data;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]   req_ready;
    logic            tx_valid, tx_sop, tx_eop;
    logic [DW-1:0]   tx_data;
    logic [AW-1:0]   tx_addr;
    logic            tx_ready;
    logic [1:0]      grant;
    logic            busy, perr;
`ifdef ACX_DS_ARB_STATS_EN
    logic            stats_clear;
    logic [NR*32-1:0] pkt_count;
`endif

    int total = 0;
    int bad   = 0;

    nap_ds_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_req_sop   (req_sop),
        .i_req_eop   (req_eop),
        .i_req_data  (req_data),
        .i_req_addr  (req_addr),
        .o_req_ready (req_ready),
        .o_tx_valid  (tx_valid),
        .o_tx_sop    (tx_sop),
        .o_tx_eop    (tx_eop),
        .o_tx_data   (tx_data),
        .o_tx_addr   (tx_addr),
        .i_tx_ready  (tx_ready),
`ifdef ACX_DS_ARB_STATS_EN
        .i_stats_clear (stats_clear),
        .o_pkt_count   (pkt_count),
`endif
        .o_grant     (grant),
        .o_busy      (busy),
        .o_proto_err (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input int k, input int b);
        logic [31:0] v;
        v = {8'(k), 8'(b), 16'hBEEF};
        return DW'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic s, input logic e, input int b);
        req_valid[k]         = v;
        req_sop[k]           = s;
        req_eop[k]           = e;
        req_data[k*DW +: DW] = mk(k, b);
        req_addr[k*AW +: AW] = 4'(k + 5);
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_sop   = '0;
        req_eop   = '0;
        req_data  = '0;
        req_addr  = '0;
    endtask

    task automatic do_reset();
        clear_all();
        tx_ready = 1'b1;
`ifdef ACX_DS_ARB_STATS_EN
        stats_clear = 1'b0;
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tx_ready = 1'b1;
        set_req(1, 1'b1, 1'b1, 1'b0, 0);
        rst = 1'b1;
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        total++; if (grant !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d exp=0", grant); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL reset_err got=%0d exp=0", perr); end
        step();
        #2;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_txvalid got=%0d exp=0", tx_valid); end
        rst = 1'b0;
        clear_all();
    endtask

    task automatic test_single();
        do_reset();
        set_req(1, 1'b1, 1'b1, 1'b0, 0);
        #3;
        total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_arb valid=%0d busy=%0d exp=0,0", tx_valid, busy); end
        step();
        for (int b = 0; b < 3; b++) begin
            set_req(1, 1'b1, b == 0, b == 2, b);
            #3;
            total++; if (busy !== 1'b1 || grant !== 2'd1) begin bad++; $display("FAIL single_grant beat=%0d busy=%0d grant=%0d exp=1,1", b, busy, grant); end
            total++; if (tx_valid !== 1'b1 || tx_sop !== (b == 0) || tx_eop !== (b == 2)) begin bad++; $display("FAIL single_ctl beat=%0d v/s/e=%0d%0d%0d", b, tx_valid, tx_sop, tx_eop); end
            total++; if (tx_data !== mk(1, b) || tx_addr !== 4'd6) begin bad++; $display("FAIL single_data beat=%0d got=%h addr=%0d exp=%h,6", b, tx_data[31:0], tx_addr, mk(1, b) & 32'hFFFFFFFF); end
            total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
            step();
        end
        clear_all();
        #3;
        total++; if (busy !== 1'b0 || grant !== 2'd1) begin bad++; $display("FAIL single_idle busy=%0d grant=%0d exp=0,1", busy, grant); end
    endtask

    task automatic test_rr();
        int beat[NR];
        int n;
        logic [NR-1:0] rdy;
        do_reset();
        n = 0;
        for (int k = 0; k < NR; k++) beat[k] = 0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            for (int k = 0; k < NR; k++) set_req(k, 1'b1, beat[k] == 0, beat[k] == 1, beat[k]);
            #3;
            total++; if (busy !== ((cyc % 3) != 0)) begin bad++; $display("FAIL rr_busy cyc=%0d got=%0d", cyc, busy); end
            if (busy && tx_sop) begin
                total++; if (grant !== 2'(n % NR)) begin bad++; $display("FAIL rr_order pkt=%0d got=%0d exp=%0d", n, grant, n % NR); end
                n++;
            end
            rdy = req_ready;
            step();
            for (int k = 0; k < NR; k++) if (rdy[k]) beat[k] = 1 - beat[k];
        end
        total++; if (n !== 6) begin bad++; $display("FAIL rr_count got=%0d exp=6", n); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL rr_err got=%0d exp=0", perr); end
        clear_all();
    endtask

    task automatic test_backpressure();
        int b;
        do_reset();
        set_req(2, 1'b1, 1'b1, 1'b0, 0);
        #3;
        step();
        b = 0;
        for (int c = 0; c < 7; c++) begin
            tx_ready = (c % 2) == 0;
            set_req(2, 1'b1, b == 0, b == 3, b);
            set_req(0, 1'b1, 1'b1, 1'b1, 0);
            #3;
            total++; if (req_ready !== (tx_ready ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL bp_ready c=%0d got=%b", c, req_ready); end
            total++; if (tx_valid !== 1'b1 || tx_data !== mk(2, b)) begin bad++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, tx_data[31:0], mk(2, b) & 32'hFFFFFFFF); end
            step();
            if (tx_ready) b++;
        end
        set_req(2, 1'b0, 1'b0, 1'b0, 0);
        tx_ready = 1'b1;
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_done got=%0d exp=0", busy); end
        step();
        #1;
        total++; if (busy !== 1'b1 || grant !== 2'd0) begin bad++; $display("FAIL bp_next busy=%0d grant=%0d exp=1,0", busy, grant); end
        clear_all();
    endtask

    task automatic test_single_beat();
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b1, 0);
        set_req(3, 1'b1, 1'b1, 1'b1, 0);
        step();
        #3;
        total++; if (grant !== 2'd0 || req_ready !== 4'b0001 || tx_eop !== 1'b1) begin bad++; $display("FAIL sb_first grant=%0d ready=%b eop=%0d", grant, req_ready, tx_eop); end
        step();
        set_req(0, 1'b0, 1'b0, 1'b0, 0);
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sb_idle got=%0d exp=0", busy); end
        step();
        #3;
        total++; if (grant !== 2'd3 || req_ready !== 4'b1000 || busy !== 1'b1) begin bad++; $display("FAIL sb_second grant=%0d ready=%b busy=%0d", grant, req_ready, busy); end
        step();
        set_req(3, 1'b0, 1'b0, 1'b0, 0);
        set_req(0, 1'b1, 1'b1, 1'b1, 0);
        set_req(3, 1'b1, 1'b1, 1'b1, 0);
        step();
        #3;
        total++; if (grant !== 2'd0) begin bad++; $display("FAIL sb_wrap got=%0d exp=0", grant); end
        clear_all();
    endtask

    task automatic test_proto_err();
        do_reset();
        set_req(1, 1'b1, 1'b0, 1'b0, 0);
        #3;
        total++; if (perr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL perr_pre err=%0d busy=%0d exp=0,0", perr, busy); end
        step();
        #3;
        total++; if (perr !== 1'b1) begin bad++; $display("FAIL perr_set got=%0d exp=1", perr); end
        clear_all();
        step();
        step();
        total++; if (perr !== 1'b1) begin bad++; $display("FAIL perr_sticky got=%0d exp=1", perr); end
        set_req(0, 1'b1, 1'b1, 1'b0, 0);
        step();
        #2;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL perr_pkt got=%0d exp=1", busy); end
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || tx_valid !== 1'b0 || perr !== 1'b0) begin bad++; $display("FAIL async_reset busy=%0d valid=%0d err=%0d exp=0,0,0", busy, tx_valid, perr); end
        step();
        rst = 1'b0;
        clear_all();
    endtask

    task automatic test_sop_err();
        do_reset();
        set_req(2, 1'b1, 1'b1, 1'b0, 0);
        step();
        step();
        set_req(2, 1'b1, 1'b1, 1'b0, 1);
        #3;
        total++; if (perr !== 1'b0 || tx_valid !== 1'b1 || tx_data !== mk(2, 1)) begin bad++; $display("FAIL sop_fwd err=%0d valid=%0d data=%h", perr, tx_valid, tx_data[31:0]); end
        step();
        set_req(2, 1'b1, 1'b0, 1'b1, 2);
        #3;
        total++; if (perr !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL sop_err err=%0d busy=%0d exp=1,1", perr, busy); end
        step();
        clear_all();
    endtask

`ifdef ACX_DS_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            set_req(2, 1'b1, 1'b1, 1'b0, 0);
            step();
            step();
            set_req(2, 1'b1, 1'b0, 1'b1, 1);
            step();
        end
        clear_all();
        #3;
        total++; if (pkt_count[64 +: 32] !== 32'd5 || pkt_count[0 +: 32] !== 32'd0) begin bad++; $display("FAIL stats_count got=%0d/%0d exp=5/0", pkt_count[64 +: 32], pkt_count[0 +: 32]); end
        set_req(2, 1'b1, 1'b1, 1'b0, 0);
        step();
        step();
        set_req(2, 1'b1, 1'b0, 1'b1, 1);
        stats_clear = 1'b1;
        step();
        stats_clear = 1'b0;
        clear_all();
        #3;
        total++; if (pkt_count[64 +: 32] !== 32'd0) begin bad++; $display("FAIL stats_clear got=%0d exp=0", pkt_count[64 +: 32]); end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        tx_ready = 1'b0;
        clear_all();
`ifdef ACX_DS_ARB_STATS_EN
        stats_clear = 1'b0;
`endif
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_single_beat();
        test_proto_err();
        test_sop_err();
`ifdef ACX_DS_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nap_ds_tx_arbiter.md
Name: nap_ds_tx_arbiter

Overview:
- Shares one data-streaming NAP transmit channel between NUM_REQ user streams.
- Arbitration is round-robin at packet granularity: once a requester is granted, its whole packet (sop through eop) passes uninterrupted.
- Sits between user packet generators and the NAP tx wrapper. Vertical or horizontal NAP is selected by DATA_WIDTH.

Parameters:
- NUM_REQ, 4, number of requesting streams (2..8).
- DATA_WIDTH, 288, stream data width (288 horizontal, 293 vertical).
- ADDR_WIDTH, 4, NAP destination address width.
- REQ_W, $clog2(NUM_REQ), grant index width (derived, localparam).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester valid.
- i_req_sop  in  NUM_REQ  per-requester start of packet.
- i_req_eop  in  NUM_REQ  per-requester end of packet.
- i_req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed destination address.
- o_req_ready  out  NUM_REQ  per-requester ready.
- o_tx_valid, o_tx_sop, o_tx_eop  out  1 each  to NAP tx.
- o_tx_data  out  DATA_WIDTH  to NAP tx.
- o_tx_addr  out  ADDR_WIDTH  to NAP tx.
- i_tx_ready  in  1  from NAP tx.
- o_grant  out  REQ_W  index of the current or last granted requester.
- o_busy  out  1  high while a packet is in progress.
- o_proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-high on i_reset.
- Reset values: state=IDLE, o_grant=0, RR pointer=0, o_busy=0, o_proto_err=0.
- Outputs during reset: o_req_ready=0, o_tx_valid=0.
- State IDLE:
  - Eligible set = i_req_valid & i_req_sop.
  - Winner = first eligible index at or after the RR pointer, wrapping modulo NUM_REQ.
  - If the eligible set is non-empty: register o_grant=winner, go to PKT.
  - Nothing is forwarded in IDLE. All o_req_ready=0 and o_tx_valid=0.
  - Arbitration costs one cycle per packet.
- State PKT:
  - Combinational pass-through from granted requester g: o_tx_valid=i_req_valid[g]; sop, eop, data and addr come from g.
  - o_req_ready[g]=i_tx_ready. All other ready bits are 0.
  - A beat transfers when o_tx_valid && i_tx_ready.
  - When a beat transfers with eop=1: go to IDLE and set the RR pointer to (g+1) mod NUM_REQ.
  - Single-beat packets (sop=eop=1) are legal and complete in one PKT cycle.
- Protocol errors. o_proto_err sets, and stays set until reset, on either:
  - a transferred beat in PKT with sop=1 that is not the packet's first beat;
  - in IDLE, i_req_valid=1 with sop=0 on any requester.
  - In both cases the data is still forwarded or held unchanged. The arbiter does not drop beats.
- Bubbles: i_req_valid[g] may drop mid-packet. The grant is held and the arbiter waits with no timeout.
- Simultaneous requests: strictly fair. No requester wins twice while another is continuously eligible.
- Reset mid-packet: the FSM returns to IDLE immediately. The partial packet is abandoned; it is the user's responsibility to flush.
- o_busy = (state==PKT).
- o_grant holds its value in IDLE.

Optional Feature:
- Macro: ACX_DS_ARB_STATS_EN.
- Defined:
  - Adds output o_pkt_count, NUM_REQ*32 bits. Each per-requester counter increments on that requester's eop transfer and wraps at 2^32.
  - Adds input i_stats_clear. When high, all counters are zeroed synchronously; clear wins over a simultaneous increment.
  - Counters reset to 0 on i_reset.
- Undefined: these ports and registers do not exist.

Decomposition:
- Package acx_ds_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_PKT} t_arb_state;
  - MAX_REQ=8;
  - function rr_pick(eligible, pointer), returning the winning index.
- Sub-module acx_rr_pick: a purely combinational rotate-priority-encoder, NUM_REQ-parameterised and reusable by other arbiters.

Test Plan:
- Single requester: 3-beat packet on req1 with i_tx_ready=1.
  - Grant at cycle 1 (o_grant=1).
  - Beats transfer at cycles 2, 3 and 4 with sop on beat 1 and eop on beat 3.
  - IDLE at cycle 5.
- All 4 requesters continuously sending 2-beat packets: grant order 0,1,2,3,0,1… Each packet takes 3 cycles; o_proto_err stays 0.
- Backpressure: i_tx_ready toggles 1,0,1,0 during a 4-beat packet on req2.
  - o_req_ready[2] mirrors i_tx_ready.
  - Data is unchanged while stalled.
  - Other ready bits stay 0.
- Single-beat packets: req0 and req3 assert sop=eop=1 simultaneously with the pointer at 0.
  - req0 is granted first, then req3.
  - Pointer ends at 0 (wrap from 3).
- Protocol errors:
  - req1 valid with sop=0 in IDLE → o_proto_err=1 the next cycle and stays 1.
  - i_reset pulse mid-packet → state IDLE, o_tx_valid=0 and o_proto_err=0 asynchronously.
- With ACX_DS_ARB_STATS_EN: 5 packets on req2 → o_pkt_count[2]=5. An i_stats_clear pulse coinciding with an eop → count=0.
